// File: rtl/execute_feedback_arbiter_pkg.sv
// ============================================================================
// Module : execute_feedback_arbiter_pkg
// Brief  : Shared defaults and helpers for the execute feedback arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package execute_feedback_arbiter_pkg;

    localparam int c_ALU_UNIT_NUM = 2;
    localparam int c_BRU_UNIT_NUM = 1;
    localparam int c_CSR_UNIT_NUM = 1;
    localparam int c_DIV_UNIT_NUM = 0;
    localparam int c_LSU_UNIT_NUM = 1;
    localparam int c_MUL_UNIT_NUM = 1;

    localparam int c_DEF_SRC_NUM = c_ALU_UNIT_NUM + c_BRU_UNIT_NUM + c_CSR_UNIT_NUM
                                 + c_DIV_UNIT_NUM + c_LSU_UNIT_NUM + c_MUL_UNIT_NUM;
    localparam int c_DEF_DST_NUM      = 4;
    localparam int c_DEF_PHY_ID_WIDTH = 6;
    localparam int c_DEF_VALUE_WIDTH  = 32;

    // Index width that stays legal when only one source exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/execute_feedback_arbiter_rr_multi_grant.sv
// ============================================================================
// Module : execute_feedback_arbiter_rr_multi_grant
// Brief  : Combinational round-robin picker granting up to M of N requests.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_feedback_arbiter_rr_multi_grant
    import execute_feedback_arbiter_pkg::*;
#(
    parameter int N  = 6,
    parameter int M  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IW-1:0]   ptr,
    output logic [N-1:0]    grant,
    output logic [M*IW-1:0] slot_src,
    output logic [M-1:0]    slot_valid,
    output logic [IW-1:0]   last_idx
);

    int w_cnt;
    int w_src;

    always_comb begin
        grant      = '0;
        slot_src   = '0;
        slot_valid = '0;
        last_idx   = '0;
        w_cnt      = 0;
        w_src      = 0;
        for (int k = 0; k < N; k++) begin
            w_src = int'(ptr) + k;
            if (w_src >= N) begin
                w_src = w_src - N;
            end
            if (req[w_src[IW-1:0]] && (w_cnt < M)) begin
                for (int i = 0; i < N; i++) begin
                    if (i == w_src) begin
                        grant[i] = 1'b1;
                    end
                end
                // Slot position equals the number of grants already issued this scan.
                for (int j = 0; j < M; j++) begin
                    if (j == w_cnt) begin
                        slot_valid[j]          = 1'b1;
                        slot_src[j*IW +: IW]   = w_src[IW-1:0];
                    end
                end
                last_idx = w_src[IW-1:0];
                w_cnt    = w_cnt + 1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/execute_feedback_arbiter.sv
// ============================================================================
// Module : execute_feedback_arbiter
// Brief  : Merges SRC_NUM execute feedback channels onto DST_NUM registered ports.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_feedback_arbiter
    import execute_feedback_arbiter_pkg::*;
#(
    parameter int SRC_NUM      = c_DEF_SRC_NUM,
    parameter int DST_NUM      = c_DEF_DST_NUM,
    parameter int PHY_ID_WIDTH = c_DEF_PHY_ID_WIDTH,
    parameter int VALUE_WIDTH  = c_DEF_VALUE_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [SRC_NUM-1:0]              src_valid,
    input  logic [SRC_NUM*PHY_ID_WIDTH-1:0] src_phy_id,
    input  logic [SRC_NUM*VALUE_WIDTH-1:0]  src_value,
    output logic [SRC_NUM-1:0]              src_ready,
    output logic [DST_NUM-1:0]              fb_enable,
    output logic [DST_NUM*PHY_ID_WIDTH-1:0] fb_phy_id,
    output logic [DST_NUM*VALUE_WIDTH-1:0]  fb_value,
    output logic [31:0]                     overflow_cnt
);

    localparam int c_IW = idx_width(SRC_NUM);

    logic [SRC_NUM-1:0]              r_pending;
    logic [PHY_ID_WIDTH-1:0]         r_hold_phy [SRC_NUM];
    logic [VALUE_WIDTH-1:0]          r_hold_val [SRC_NUM];
    logic [c_IW-1:0]                 r_rr_ptr;
    logic [DST_NUM-1:0]              r_fb_enable;
    logic [DST_NUM*PHY_ID_WIDTH-1:0] r_fb_phy_id;
    logic [DST_NUM*VALUE_WIDTH-1:0]  r_fb_value;
    logic [31:0]                     r_overflow_cnt;

    logic [SRC_NUM-1:0]              w_grant;
    logic [DST_NUM*c_IW-1:0]         w_slot_src;
    logic [DST_NUM-1:0]              w_slot_valid;
    logic [c_IW-1:0]                 w_last_idx;
    logic [c_IW-1:0]                 w_rr_next;
    logic                            w_overflow;
    logic [DST_NUM-1:0]              w_fb_enable;
    logic [DST_NUM*PHY_ID_WIDTH-1:0] w_fb_phy_id;
    logic [DST_NUM*VALUE_WIDTH-1:0]  w_fb_value;

    execute_feedback_arbiter_rr_multi_grant #(
        .N  (SRC_NUM),
        .M  (DST_NUM),
        .IW (c_IW)
    ) u_rr_multi_grant (
        .req        (r_pending),
        .ptr        (r_rr_ptr),
        .grant      (w_grant),
        .slot_src   (w_slot_src),
        .slot_valid (w_slot_valid),
        .last_idx   (w_last_idx)
    );

    // A granted entry frees its slot in the same cycle, so the source may refill it.
    assign src_ready  = {SRC_NUM{~flush}} & (~r_pending | w_grant);
    assign w_overflow = ($countones(r_pending) > DST_NUM);
    assign w_rr_next  = ((int'(w_last_idx) + 1) >= SRC_NUM) ? '0 : (w_last_idx + c_IW'(1));

    always_comb begin
        w_fb_enable = '0;
        w_fb_phy_id = '0;
        w_fb_value  = '0;
        for (int j = 0; j < DST_NUM; j++) begin
            if (w_slot_valid[j]) begin
                w_fb_enable[j]                          = 1'b1;
                w_fb_phy_id[j*PHY_ID_WIDTH +: PHY_ID_WIDTH] = r_hold_phy[w_slot_src[j*c_IW +: c_IW]];
                w_fb_value[j*VALUE_WIDTH +: VALUE_WIDTH]    = r_hold_val[w_slot_src[j*c_IW +: c_IW]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_fb_enable    <= '0;
            r_fb_phy_id    <= '0;
            r_fb_value     <= '0;
            r_overflow_cnt <= '0;
            for (int i = 0; i < SRC_NUM; i++) begin
                r_hold_phy[i] <= '0;
                r_hold_val[i] <= '0;
            end
        end else if (flush) begin
            r_pending   <= '0;
            r_fb_enable <= '0;
            r_fb_phy_id <= '0;
            r_fb_value  <= '0;
        end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    r_pending[i]  <= 1'b1;
                    r_hold_phy[i] <= src_phy_id[i*PHY_ID_WIDTH +: PHY_ID_WIDTH];
                    r_hold_val[i] <= src_value[i*VALUE_WIDTH +: VALUE_WIDTH];
                end else if (w_grant[i]) begin
                    r_pending[i]  <= 1'b0;
                end
            end
            r_fb_enable <= w_fb_enable;
            r_fb_phy_id <= w_fb_phy_id;
            r_fb_value  <= w_fb_value;
            if (|w_grant) begin
                r_rr_ptr <= w_rr_next;
            end
            if (w_overflow && (r_overflow_cnt != 32'hFFFF_FFFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 32'd1;
            end
        end
    end

    assign fb_enable    = r_fb_enable;
    assign fb_phy_id    = r_fb_phy_id;
    assign fb_value     = r_fb_value;
    assign overflow_cnt = r_overflow_cnt;

endmodule

`default_nettype wire

// File: tb/tb_execute_feedback_arbiter.sv
// ============================================================================
// Module : tb_execute_feedback_arbiter
// Brief  : Self-checking bench: directed vector table, corner sequences, random vs model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_feedback_arbiter;

    localparam int S  = 6;
    localparam int D  = 4;
    localparam int PW = 6;
    localparam int VW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [S-1:0]    src_valid;
    logic [S*PW-1:0] src_phy_id;
    logic [S*VW-1:0] src_value;
    logic [S-1:0]    src_ready;
    logic [D-1:0]    fb_enable;
    logic [D*PW-1:0] fb_phy_id;
    logic [D*VW-1:0] fb_value;
    logic [31:0]     overflow_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    execute_feedback_arbiter #(
        .SRC_NUM      (S),
        .DST_NUM      (D),
        .PHY_ID_WIDTH (PW),
        .VALUE_WIDTH  (VW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .src_valid    (src_valid),
        .src_phy_id   (src_phy_id),
        .src_value    (src_value),
        .src_ready    (src_ready),
        .fb_enable    (fb_enable),
        .fb_phy_id    (fb_phy_id),
        .fb_value     (fb_value),
        .overflow_cnt (overflow_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit [S-1:0] v, input logic [31:0] vbase);
        rst       = r;
        flush     = f;
        src_valid = v;
        for (int i = 0; i < S; i++) begin
            src_phy_id[i*PW +: PW] = PW'(i + 1);
            src_value[i*VW +: VW]  = vbase + 32'(i);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        bit        r;
        bit        f;
        bit [5:0]  v;
        bit        chk_rdy;
        bit [5:0]  rdy;
        bit [3:0]  en;
        bit [11:0] sl;
        bit [31:0] ovf;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit f, input bit [5:0] v, input bit c,
                                input bit [5:0] rdy, input bit [3:0] en,
                                input int a, input int b, input int cc, input int d, input int ovf);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.chk_rdy = c; t.rdy = rdy; t.en = en;
        t.sl = {3'(d), 3'(cc), 3'(b), 3'(a)};
        t.ovf = 32'(ovf);
        return t;
    endfunction

    vec_t vecs [17];

    // ---------------- reference model ----------------
    bit          m_pend [S];
    bit [PW-1:0] m_phy  [S];
    bit [VW-1:0] m_val  [S];
    int          m_rr;
    bit [D-1:0]    m_fb_en;
    bit [D*PW-1:0] m_fb_phy;
    bit [D*VW-1:0] m_fb_val;
    bit [31:0]     m_ovf;
    int            g_list [$];

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_pend[i] = 0; m_phy[i] = '0; m_val[i] = '0;
        end
        m_rr = 0; m_fb_en = '0; m_fb_phy = '0; m_fb_val = '0; m_ovf = '0;
    endtask

    task automatic model_grants();
        g_list.delete();
        for (int k = 0; k < S; k++) begin
            int s;
            s = (m_rr + k) % S;
            if (m_pend[s] && g_list.size() < D) g_list.push_back(s);
        end
    endtask

    function automatic bit is_granted(input int s);
        foreach (g_list[q]) if (g_list[q] == s) return 1;
        return 0;
    endfunction

    function automatic bit [S-1:0] model_ready();
        bit [S-1:0] rd;
        for (int i = 0; i < S; i++) rd[i] = !flush && (!m_pend[i] || is_granted(i));
        return rd;
    endfunction

    task automatic model_step();
        bit [S-1:0] rd;
        int         npend;
        rd    = model_ready();
        npend = 0;
        for (int i = 0; i < S; i++) npend += int'(m_pend[i]);
        if (rst) begin
            model_reset();
        end else if (flush) begin
            for (int i = 0; i < S; i++) m_pend[i] = 0;
            m_fb_en = '0; m_fb_phy = '0; m_fb_val = '0;
        end else begin
            m_fb_en = '0; m_fb_phy = '0; m_fb_val = '0;
            foreach (g_list[j]) begin
                m_fb_en[j] = 1'b1;
                m_fb_phy[j*PW +: PW] = m_phy[g_list[j]];
                m_fb_val[j*VW +: VW] = m_val[g_list[j]];
            end
            for (int i = 0; i < S; i++) begin
                if (src_valid[i] && rd[i]) begin
                    m_pend[i] = 1;
                    m_phy[i]  = src_phy_id[i*PW +: PW];
                    m_val[i]  = src_value[i*VW +: VW];
                end else if (is_granted(i)) begin
                    m_pend[i] = 0;
                end
            end
            if (g_list.size() > 0) m_rr = (g_list[g_list.size()-1] + 1) % S;
            if (npend > D && m_ovf != 32'hFFFF_FFFF) m_ovf = m_ovf + 1;
        end
    endtask

    initial begin
        vecs[0]  = mk(1,0,6'h3F,0,6'h00,4'h0,0,0,0,0,0);
        vecs[1]  = mk(1,0,6'h3F,1,6'h3F,4'h0,0,0,0,0,0);
        vecs[2]  = mk(0,0,6'h00,1,6'h3F,4'h0,0,0,0,0,0);
        vecs[3]  = mk(0,0,6'h04,1,6'h3F,4'h0,0,0,0,0,0);
        vecs[4]  = mk(0,0,6'h00,1,6'h3F,4'h1,2,0,0,0,0);
        vecs[5]  = mk(0,0,6'h00,1,6'h3F,4'h0,0,0,0,0,0);
        vecs[6]  = mk(1,0,6'h00,1,6'h3F,4'h0,0,0,0,0,0);
        vecs[7]  = mk(0,0,6'h3F,1,6'h3F,4'h0,0,0,0,0,0);
        vecs[8]  = mk(0,0,6'h3F,1,6'h0F,4'hF,0,1,2,3,1);
        vecs[9]  = mk(0,0,6'h3F,1,6'h33,4'hF,4,5,0,1,2);
        vecs[10] = mk(0,0,6'h00,1,6'h3C,4'hF,2,3,4,5,3);
        vecs[11] = mk(0,0,6'h00,1,6'h3F,4'h3,0,1,0,0,3);
        vecs[12] = mk(0,0,6'h3F,1,6'h3F,4'h0,0,0,0,0,3);
        vecs[13] = mk(0,1,6'h3F,1,6'h00,4'h0,0,0,0,0,3);
        vecs[14] = mk(0,0,6'h00,1,6'h3F,4'h0,0,0,0,0,3);
        vecs[15] = mk(0,0,6'h3F,1,6'h3F,4'h0,0,0,0,0,3);
        vecs[16] = mk(0,0,6'h00,1,6'h3C,4'hF,2,3,4,5,4);

        drive(1, 0, '0, 32'hA000_0000);
        @(negedge clk);
        foreach (vecs[n]) begin
            drive(vecs[n].r, vecs[n].f, vecs[n].v, 32'hA000_0000);
            #1;
            if (vecs[n].chk_rdy) chk($sformatf("vec%0d src_ready", n), 64'(src_ready), 64'(vecs[n].rdy));
            @(negedge clk);
            chk($sformatf("vec%0d fb_enable", n), 64'(fb_enable), 64'(vecs[n].en));
            for (int k = 0; k < D; k++) begin
                logic [PW-1:0] ephy;
                logic [VW-1:0] eval;
                int            s;
                s    = int'(vecs[n].sl[k*3 +: 3]);
                ephy = vecs[n].en[k] ? PW'(s + 1) : '0;
                eval = vecs[n].en[k] ? (32'hA000_0000 + 32'(s)) : '0;
                chk($sformatf("vec%0d slot%0d phy", n, k), 64'(fb_phy_id[k*PW +: PW]), 64'(ephy));
                chk($sformatf("vec%0d slot%0d value", n, k), 64'(fb_value[k*VW +: VW]), 64'(eval));
            end
            chk($sformatf("vec%0d overflow_cnt", n), 64'(overflow_cnt), 64'(vecs[n].ovf));
        end

        // Back-pressure: src 4/5 stay held while refused; held values emerge unchanged.
        drive(1, 0, '0, 32'h0);
        @(negedge clk);
        drive(0, 0, 6'h3F, 32'h1111_0000);
        @(negedge clk);
        drive(0, 0, 6'h3F, 32'h2222_0000);
        #1;
        chk("bp src_ready", 64'(src_ready), 64'h0F);
        @(negedge clk);
        chk("bp first slot0 value", 64'(fb_value[0 +: VW]), 64'h1111_0000);
        drive(0, 0, 6'h00, 32'h3333_0000);
        #1;
        chk("bp src_ready 2", 64'(src_ready), 64'h33);
        @(negedge clk);
        chk("bp src4 held value", 64'(fb_value[0 +: VW]), 64'h1111_0004);
        chk("bp src5 held value", 64'(fb_value[VW +: VW]), 64'h1111_0005);
        chk("bp src0 new value", 64'(fb_value[2*VW +: VW]), 64'h2222_0000);

        // Saturation: keep all six sources pending, preload the counter near its ceiling.
        drive(1, 0, '0, 32'h0);
        @(negedge clk);
        drive(0, 0, 6'h3F, 32'h4444_0000);
        @(negedge clk);
        force dut.r_overflow_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_overflow_cnt;
        @(negedge clk);
        chk("sat step1", 64'(overflow_cnt), 64'hFFFF_FFFF);
        @(negedge clk);
        chk("sat step2", 64'(overflow_cnt), 64'hFFFF_FFFF);

        // Random traffic against the reference model.
        drive(1, 0, '0, 32'h0);
        @(negedge clk);
        model_reset();
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 60) == 0);
            flush = ($urandom_range(0, 12) == 0);
            for (int i = 0; i < S; i++) begin
                src_valid[i]           = ($urandom_range(0, 3) != 0);
                src_phy_id[i*PW +: PW] = PW'($urandom);
                src_value[i*VW +: VW]  = $urandom;
            end
            #1;
            model_grants();
            chk($sformatf("rand%0d src_ready", c), 64'(src_ready), 64'(model_ready()));
            model_step();
            @(negedge clk);
            chk($sformatf("rand%0d fb_enable", c), 64'(fb_enable), 64'(m_fb_en));
            chk($sformatf("rand%0d fb_phy_id", c), 64'(fb_phy_id), 64'(m_fb_phy));
            for (int k = 0; k < D; k++)
                chk($sformatf("rand%0d fb_value%0d", c, k), 64'(fb_value[k*VW +: VW]), 64'(m_fb_val[k*VW +: VW]));
            chk($sformatf("rand%0d overflow_cnt", c), 64'(overflow_cnt), 64'(m_ovf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
